// File: rtl/async_elastic_operator_pkg.sv
// Shared definitions for the elastic operator node: op encoding and arity classification.
package async_elastic_operator_pkg;

    typedef enum logic [3:0] {
        OpReg,
        OpIn,
        OpOut,
        OpAddi,
        OpSubi,
        OpMuli,
        OpAdd,
        OpSub,
        OpMul,
        OpMin,
        OpMax,
        OpBad
    } op_e;

    function automatic logic op_is_unary(op_e op);
        return op inside {OpReg, OpIn, OpOut, OpAddi, OpSubi, OpMuli};
    endfunction

endpackage

// File: rtl/async_elastic_operator_sync_fifo.sv
// Result buffer for the operator node; push into full / pop from empty are ignored.
module async_elastic_operator_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic [DATA_WIDTH-1:0]       din_i,
    output logic [DATA_WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0]      count_o
);
    localparam int unsigned AddrW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AddrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AddrW:0]        count_q, count_d;
    logic                  do_push, do_pop;

    assign do_push = push_i && (count_q != (AddrW + 1)'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din_i;
    end

    assign head_o  = mem[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/async_elastic_operator.sv
// Dataflow operator node: collects one operand per producer, buffers op results in a FIFO and
// hands each result to every consumer exactly once before popping it.
module async_elastic_operator
    import async_elastic_operator_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter string       OP          = "add",
    parameter longint      IMMEDIATE   = 0,
    parameter int unsigned INPUT_SIZE  = 2,
    parameter int unsigned OUTPUT_SIZE = 1,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic [INPUT_SIZE-1:0]            req_l_o,
    input  logic [INPUT_SIZE-1:0]            ack_l_i,
    input  logic [DATA_WIDTH*INPUT_SIZE-1:0] din_i,
    input  logic [OUTPUT_SIZE-1:0]           req_r_i,
    output logic [OUTPUT_SIZE-1:0]           ack_r_o,
    output logic [DATA_WIDTH-1:0]            dout_o,
    output logic [$clog2(DEPTH):0]           occupancy_o
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam op_e OpSel =
        (OP == "reg")  ? OpReg  : (OP == "in")   ? OpIn   : (OP == "out")  ? OpOut  :
        (OP == "addi") ? OpAddi : (OP == "subi") ? OpSubi : (OP == "muli") ? OpMuli :
        (OP == "add")  ? OpAdd  : (OP == "sub")  ? OpSub  : (OP == "mul")  ? OpMul  :
        (OP == "min")  ? OpMin  : (OP == "max")  ? OpMax  : OpBad;

    if (OpSel == OpBad || INPUT_SIZE == 0 || INPUT_SIZE > 4 || OUTPUT_SIZE == 0 ||
        OUTPUT_SIZE > 8 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        op_is_unary(OpSel) != (INPUT_SIZE == 1)) begin : g_illegal
        $fatal(1, "async_elastic_operator: illegal OP/INPUT_SIZE/OUTPUT_SIZE/DEPTH");
    end

    logic [INPUT_SIZE-1:0]  has_q, has_d, req_l_q, req_l_d;
    logic [DATA_WIDTH-1:0]  opnd_q [INPUT_SIZE];
    // Operands plus the immediate as a trailing slot, read by the unary ops.
    logic [DATA_WIDTH-1:0]  src [INPUT_SIZE+1];
    logic [DATA_WIDTH-1:0]  result, head, last_q;
    logic [CntW-1:0]        count;
    logic [OUTPUT_SIZE-1:0] served_q, served_d, ack_r_q, ack_r_d;
    logic                   push, pop;

    assign push = (&has_q) && (count < CntW'(DEPTH));

    always_comb begin
        has_d   = has_q;
        req_l_d = req_l_q;
        for (int i = 0; i < int'(INPUT_SIZE); i++) begin
            if (push) has_d[i] = 1'b0;
            if (ack_l_i[i]) begin
                has_d[i]   = 1'b1;
                req_l_d[i] = 1'b0;
            end else if (!has_q[i] && !req_l_q[i]) begin
                req_l_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(INPUT_SIZE); i++) begin
            if (ack_l_i[i]) opnd_q[i] <= din_i[DATA_WIDTH*i +: DATA_WIDTH];
        end
    end

    always_comb begin
        for (int i = 0; i < int'(INPUT_SIZE); i++) src[i] = opnd_q[i];
        src[INPUT_SIZE] = DATA_WIDTH'(IMMEDIATE);
    end

    if (OpSel == OpAddi) begin : g_addi
        assign result = src[0] + src[1];
    end else if (OpSel == OpSubi) begin : g_subi
        assign result = src[0] - src[1];
    end else if (OpSel == OpMuli) begin : g_muli
        assign result = src[0] * src[1];
    end else if (op_is_unary(OpSel)) begin : g_pass
        assign result = src[0];
    end else begin : g_nary
        always_comb begin
            result = src[0];
            for (int i = 1; i < int'(INPUT_SIZE); i++) begin
                if (OpSel == OpAdd)      result = result + src[i];
                else if (OpSel == OpSub) result = result - src[i];
                else if (OpSel == OpMul) result = result * src[i];
                else if (OpSel == OpMin) result = (src[i] < result) ? src[i] : result;
                else                     result = (src[i] > result) ? src[i] : result;
            end
        end
    end

    // Pop only once every consumer has been served and its ack pulse has ended.
    assign pop = (&served_q) && !(|ack_r_q);

    always_comb begin
        for (int j = 0; j < int'(OUTPUT_SIZE); j++) begin
            ack_r_d[j] = (count != '0) && req_r_i[j] && !served_q[j] && !ack_r_q[j];
        end
        served_d = pop ? '0 : (served_q | ack_r_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            has_q    <= '0;
            req_l_q  <= '0;
            served_q <= '0;
            ack_r_q  <= '0;
            last_q   <= '0;
        end else begin
            has_q    <= has_d;
            req_l_q  <= req_l_d;
            served_q <= served_d;
            ack_r_q  <= ack_r_d;
            if (pop) last_q <= head;
        end
    end

    async_elastic_operator_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (result),
        .head_o  (head),
        .count_o (count)
    );

    assign req_l_o     = req_l_q;
    assign ack_r_o     = ack_r_q;
    assign dout_o      = (count == '0) ? last_q : head;
    assign occupancy_o = count;

endmodule

// File: tb/tb_async_elastic_operator.sv
// Scoreboard bench for a 3-input subtract node with two consumers and a 4-entry buffer.
module tb_async_elastic_operator;
    localparam int W   = 32;
    localparam int IN  = 3;
    localparam int OUT = 2;
    localparam int D   = 4;

    typedef logic [W-1:0] word_q_t[$];

    logic            clk = 1'b0;
    logic            rst;
    logic [IN-1:0]   req_l, ack_l;
    logic [W*IN-1:0] din;
    logic [OUT-1:0]  req_r, ack_r;
    logic [W-1:0]    dout;
    logic [$clog2(D):0] occ;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit prod_en = 1'b0;
    int prod_rate = 100;
    int cons_mode = 0;
    int tuple_cyc = -1;

    word_q_t chan_q [IN];
    word_q_t dir_q  [IN];
    word_q_t exp_q  [OUT];

    async_elastic_operator #(
        .DATA_WIDTH  (W),
        .OP          ("sub"),
        .IMMEDIATE   (0),
        .INPUT_SIZE  (IN),
        .OUTPUT_SIZE (OUT),
        .DEPTH       (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_l_o     (req_l),
        .ack_l_i     (ack_l),
        .din_i       (din),
        .req_r_i     (req_r),
        .ack_r_o     (ack_r),
        .dout_o      (dout),
        .occupancy_o (occ)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic bit all_channels_ready();
        for (int i = 0; i < IN; i++) if (chan_q[i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    // Producers: ack a pending request with a value; every complete set of operands
    // yields one expected result per consumer (slice0 - slice1 - slice2, mod 2^32).
    initial begin
        logic [W-1:0] v, r;
        ack_l = '0;
        din   = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < IN; i++) begin
                ack_l[i] = 1'b0;
                if (prod_en && !rst && req_l[i] && ($urandom_range(99) < prod_rate)) begin
                    v = (dir_q[i].size() > 0) ? dir_q[i].pop_front() : $urandom();
                    din[W*i +: W] = v;
                    ack_l[i] = 1'b1;
                    chan_q[i].push_back(v);
                end
            end
            while (all_channels_ready()) begin
                r = chan_q[0].pop_front();
                for (int i = 1; i < IN; i++) r = r - chan_q[i].pop_front();
                for (int j = 0; j < OUT; j++) exp_q[j].push_back(r);
                if (tuple_cyc < 0) tuple_cyc = cyc;
            end
        end
    end

    // Consumers: 0 idle, 1 c0 always / c1 every 10th cycle, 2 random, 3 both always.
    initial begin
        req_r = '0;
        forever begin
            @(negedge clk);
            case (cons_mode)
                1: begin
                    req_r[0] = 1'b1;
                    req_r[1] = (cyc % 10 == 0);
                end
                2:       req_r = OUT'($urandom());
                3:       req_r = '1;
                default: req_r = '0;
            endcase
        end
    end

    // Monitor: every ack must present the next expected result for that consumer.
    initial forever begin
        logic [W-1:0] e;
        @(negedge clk);
        if (!rst) begin
            for (int j = 0; j < OUT; j++) begin
                if (ack_r[j]) begin
                    if (exp_q[j].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack c%0d: got ack with dout=%0h, required no ack",
                                 j, dout);
                    end else begin
                        e = exp_q[j].pop_front();
                        check($sformatf("dout_c%0d", j), 64'(dout), 64'(e));
                    end
                end
            end
            checks++;
            if (occ > D) begin
                errors++;
                $display("FAIL occupancy_bound: got %0d, required <= %0d", occ, D);
            end
        end
    end

    task automatic wait_ack0(input int budget, output bit ok);
        int k = 0;
        ok = 1'b0;
        while (!ok && k < budget) begin
            @(negedge clk);
            k++;
            if (ack_r[0]) ok = 1'b1;
        end
    endtask

    task automatic drain(input string tag);
        int k = 0;
        prod_en = 1'b0;
        cons_mode = 3;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_left_c0"}, 64'(exp_q[0].size()), 64'd0);
        check({tag, "_left_c1"}, 64'(exp_q[1].size()), 64'd0);
        repeat (6) @(negedge clk);
        check({tag, "_occupancy"}, 64'(occ), 64'd0);
    endtask

    initial begin
        bit ok;
        int k;
        rst = 1'b1;
        dir_q[0].push_back(32'd10); dir_q[0].push_back(32'd0);
        dir_q[1].push_back(32'd3);  dir_q[1].push_back(32'd1);
        dir_q[2].push_back(32'd2);  dir_q[2].push_back(32'd0);
        repeat (3) @(negedge clk);
        check("reset_req_l", 64'(req_l), 64'd0);
        check("reset_ack_r", 64'(ack_r), 64'd0);
        check("reset_occupancy", 64'(occ), 64'd0);
        check("reset_dout", 64'(dout), 64'd0);

        // Directed operands, then the arithmetic wrap case.
        rst = 1'b0;
        prod_en = 1'b1;
        prod_rate = 100;
        cons_mode = 3;
        wait_ack0(60, ok);
        check("first_ack_seen", 64'(ok), 64'd1);
        check("first_dout", 64'(dout), 64'd5);
        check("first_latency", 64'(cyc - tuple_cyc), 64'd3);
        @(negedge clk);
        wait_ack0(60, ok);
        check("second_ack_seen", 64'(ok), 64'd1);
        check("wrap_dout", 64'(dout), 64'hFFFF_FFFF);

        // Backpressure: four buffered results plus one held operand set.
        cons_mode = 0;
        repeat (40) @(negedge clk);
        check("full_occupancy", 64'(occ), 64'(D));
        check("full_req_l", 64'(req_l), 64'd0);
        check("full_pending", 64'(exp_q[0].size()), 64'(D + 1));
        cons_mode = 3;
        prod_rate = 60;
        repeat (60) @(negedge clk);

        cons_mode = 1;
        repeat (300) @(negedge clk);
        cons_mode = 2;
        prod_rate = 80;
        repeat (300) @(negedge clk);
        drain("drain1");

        // Reset with buffered results and partially captured operands.
        cons_mode = 0;
        prod_en = 1'b1;
        prod_rate = 50;
        k = 0;
        while (occ != 3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("pre_reset_occupancy", 64'(occ), 64'd3);
        prod_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_req_l", 64'(req_l), 64'd0);
        check("midreset_ack_r", 64'(ack_r), 64'd0);
        check("midreset_occupancy", 64'(occ), 64'd0);
        check("midreset_dout", 64'(dout), 64'd0);
        for (int i = 0; i < IN; i++) chan_q[i].delete();
        for (int j = 0; j < OUT; j++) exp_q[j].delete();
        rst = 1'b0;
        prod_en = 1'b1;
        prod_rate = 70;
        cons_mode = 3;
        repeat (150) @(negedge clk);
        drain("drain2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no end of test, required completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

endmodule
